// File: rtl/demux4bit_4_frame.sv
// ============================================================================
// Module      : demux4bit_4_frame
// Description : Registered 1-to-4 nibble demultiplexer with frame assembly.
//               Four staging lanes are filled, then moved into a stable
//               output bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux4bit_4_frame #(
    parameter int WIDTH   = 4,
    parameter bit AUTOCLR = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] Din,
    input  logic             S0,
    input  logic             S1,
    input  logic             EN,
    input  logic             FLUSH,
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    output logic [WIDTH-1:0] Y2,
    output logic [WIDTH-1:0] Y3,
    output logic [3:0]       FILL,
    output logic             FRAME,
    output logic             ERR
);

    localparam int       c_LANES = 4;
    localparam bit [3:0] c_FULL  = 4'b1111;

    logic [WIDTH-1:0] r_stage [c_LANES];
    logic [WIDTH-1:0] r_y     [c_LANES];
    logic [3:0]       r_fill;
    logic             r_frame;
    logic             r_err;

    logic [1:0]       w_lane;
    logic [3:0]       w_lane_hot;
    logic [3:0]       w_fill_base;
    logic [3:0]       w_fill_or;
    logic [3:0]       w_fill_next;
    logic             w_complete;
    logic             w_overwrite;

    // A flush empties the flags before the same-cycle write is merged in,
    // so a flush+write starts a fresh frame and can never flag an overwrite.
    always_comb begin
        w_lane      = {S1, S0};
        w_lane_hot  = 4'b0001 << w_lane;
        w_fill_base = FLUSH ? 4'b0000 : r_fill;
        w_fill_or   = w_fill_base | w_lane_hot;
        w_complete  = EN && (w_fill_or == c_FULL);
        w_overwrite = AUTOCLR && EN && w_fill_base[w_lane];
    end

    always_comb begin
        w_fill_next = r_fill;
        if (EN) begin
            w_fill_next = (w_complete && AUTOCLR) ? 4'b0000 : w_fill_or;
        end else if (FLUSH) begin
            w_fill_next = 4'b0000;
        end
    end

    // The lane written on the completing edge bypasses its staging register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < c_LANES; i++) begin
                r_stage[i] <= '0;
                r_y[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < c_LANES; i++) begin
                if (EN && w_lane_hot[i]) begin
                    r_stage[i] <= Din;
                end
                if (w_complete) begin
                    r_y[i] <= w_lane_hot[i] ? Din : r_stage[i];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fill  <= 4'b0000;
            r_frame <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_fill  <= w_fill_next;
            r_frame <= w_complete;
            r_err   <= w_overwrite;
        end
    end

    assign Y0    = r_y[0];
    assign Y1    = r_y[1];
    assign Y2    = r_y[2];
    assign Y3    = r_y[3];
    assign FILL  = r_fill;
    assign FRAME = r_frame;
    assign ERR   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_demux4bit_4_frame.sv
// ============================================================================
// Module      : tb_demux4bit_4_frame
// Description : Self-checking bench for demux4bit_4_frame, framed and rolling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux4bit_4_frame;

    logic       CLK;
    logic       RST;
    logic [3:0] Din;
    logic       S0;
    logic       S1;
    logic       EN;
    logic       FLUSH;

    logic [3:0] a_y0, a_y1, a_y2, a_y3, a_fill;
    logic       a_frame, a_err;
    logic [3:0] b_y0, b_y1, b_y2, b_y3, b_fill;
    logic       b_frame, b_err;

    int checks = 0;
    int errors = 0;

    demux4bit_4_frame #(.WIDTH(4), .AUTOCLR(1'b1)) u_framed (
        .CLK(CLK), .RST(RST), .Din(Din), .S0(S0), .S1(S1), .EN(EN), .FLUSH(FLUSH),
        .Y0(a_y0), .Y1(a_y1), .Y2(a_y2), .Y3(a_y3),
        .FILL(a_fill), .FRAME(a_frame), .ERR(a_err)
    );

    demux4bit_4_frame #(.WIDTH(4), .AUTOCLR(1'b0)) u_rolling (
        .CLK(CLK), .RST(RST), .Din(Din), .S0(S0), .S1(S1), .EN(EN), .FLUSH(FLUSH),
        .Y0(b_y0), .Y1(b_y1), .Y2(b_y2), .Y3(b_y3),
        .FILL(b_fill), .FRAME(b_frame), .ERR(b_err)
    );

    wire [21:0] obs_a = {a_y3, a_y2, a_y1, a_y0, a_fill, a_frame, a_err};
    wire [21:0] obs_b = {b_y3, b_y2, b_y1, b_y0, b_fill, b_frame, b_err};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: index 0 = framed instance, 1 = rolling instance.
    logic [3:0] m_stage [2][4];
    logic [3:0] m_y     [2][4];
    logic [3:0] m_fill  [2];
    logic       m_frame [2];
    logic       m_err   [2];

    task automatic model_update(input int m, input bit rst, input bit en,
                                input bit flush, input int lane, input logic [3:0] din);
        bit autoclr = (m == 0);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_stage[m][i] = 4'h0;
                m_y[m][i]     = 4'h0;
            end
            m_fill[m]  = 4'h0;
            m_frame[m] = 1'b0;
            m_err[m]   = 1'b0;
        end else begin
            m_frame[m] = 1'b0;
            m_err[m]   = 1'b0;
            if (flush) m_fill[m] = 4'h0;
            if (en) begin
                if (autoclr && m_fill[m][lane]) m_err[m] = 1'b1;
                m_fill[m][lane]  = 1'b1;
                m_stage[m][lane] = din;
                if (m_fill[m] == 4'hF) begin
                    for (int i = 0; i < 4; i++) m_y[m][i] = m_stage[m][i];
                    m_frame[m] = 1'b1;
                    if (autoclr) m_fill[m] = 4'h0;
                end
            end
        end
    endtask

    function automatic logic [21:0] exp_pack(input int m);
        return {m_y[m][3], m_y[m][2], m_y[m][1], m_y[m][0], m_fill[m], m_frame[m], m_err[m]};
    endfunction

    // Applies one cycle of stimulus; outputs are observed 1 time unit after the edge.
    task automatic step(input bit rst, input bit en, input bit flush,
                        input int lane, input logic [3:0] din);
        RST = rst; EN = en; FLUSH = flush; S1 = lane[1]; S0 = lane[0]; Din = din;
        @(posedge CLK);
        model_update(0, rst, en, flush, lane, din);
        model_update(1, rst, en, flush, lane, din);
        #1;
        RST = 1'b0; EN = 1'b0; FLUSH = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 1, 1, 2, 4'h7);
        step(1, 0, 0, 0, 4'h0);
        checks++;
        if (obs_a !== 22'h0) begin
            errors++; $display("FAIL reset_framed got %h want %h", obs_a, 22'h0);
        end
        checks++;
        if (obs_b !== 22'h0) begin
            errors++; $display("FAIL reset_rolling got %h want %h", obs_b, 22'h0);
        end
    endtask

    task automatic test_in_order();
        logic [3:0] din_t  [4];
        logic [3:0] fill_t [3];
        din_t  = '{4'hA, 4'h9, 4'h8, 4'h8};
        fill_t = '{4'b0001, 4'b0011, 4'b0111};
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, i, din_t[i]);
            checks++;
            if (a_fill !== fill_t[i] || a_frame !== 1'b0) begin
                errors++;
                $display("FAIL in_order_fill%0d got fill=%b frame=%b want fill=%b frame=0",
                         i, a_fill, a_frame, fill_t[i]);
            end
        end
        step(0, 1, 0, 3, din_t[3]);
        checks++;
        if (obs_a !== {4'h8, 4'h8, 4'h9, 4'hA, 4'h0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL in_order_frame got %h want %h", obs_a,
                               {4'h8, 4'h8, 4'h9, 4'hA, 4'h0, 1'b1, 1'b0});
        end
        step(0, 0, 0, 0, 4'h0);
        checks++;
        if (obs_a !== {4'h8, 4'h8, 4'h9, 4'hA, 4'h0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL in_order_hold got %h want %h", obs_a,
                               {4'h8, 4'h8, 4'h9, 4'hA, 4'h0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_out_of_order();
        step(0, 1, 0, 3, 4'h1);
        step(0, 1, 0, 1, 4'h6);
        step(0, 1, 0, 0, 4'hF);
        checks++;
        if ({a_y3, a_y2, a_y1, a_y0} !== 16'h889A || a_fill !== 4'b1011) begin
            errors++; $display("FAIL ooo_before got y=%h fill=%b want y=889a fill=1011",
                               {a_y3, a_y2, a_y1, a_y0}, a_fill);
        end
        step(0, 1, 0, 2, 4'h2);
        checks++;
        if (obs_a !== {4'h1, 4'h2, 4'h6, 4'hF, 4'h0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL ooo_frame got %h want %h", obs_a,
                               {4'h1, 4'h2, 4'h6, 4'hF, 4'h0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_overwrite();
        step(0, 1, 0, 2, 4'hE);
        step(0, 1, 0, 2, 4'h3);
        checks++;
        if (a_err !== 1'b1 || a_fill !== 4'b0100 || a_frame !== 1'b0) begin
            errors++; $display("FAIL overwrite_err got err=%b fill=%b frame=%b want 1 0100 0",
                               a_err, a_fill, a_frame);
        end
        step(0, 1, 0, 0, 4'h0);
        checks++;
        if (a_err !== 1'b0 || a_fill !== 4'b0101) begin
            errors++; $display("FAIL overwrite_pulse got err=%b fill=%b want 0 0101", a_err, a_fill);
        end
        step(0, 1, 0, 1, 4'h0);
        step(0, 1, 0, 3, 4'h0);
        checks++;
        if (obs_a !== {4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL overwrite_frame got %h want %h", obs_a,
                               {4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_flush();
        step(0, 1, 0, 0, 4'h5);
        step(0, 1, 0, 1, 4'hC);
        checks++;
        if (a_fill !== 4'b0011) begin
            errors++; $display("FAIL flush_pre got fill=%b want 0011", a_fill);
        end
        step(0, 0, 1, 0, 4'h0);
        checks++;
        if (obs_a !== {4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL flush_only got %h want %h", obs_a,
                               {4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0});
        end
        step(0, 1, 1, 3, 4'hB);
        checks++;
        if (a_fill !== 4'b1000 || a_err !== 1'b0 || a_frame !== 1'b0) begin
            errors++; $display("FAIL flush_write got fill=%b err=%b frame=%b want 1000 0 0",
                               a_fill, a_err, a_frame);
        end
    endtask

    task automatic test_reset_midframe();
        step(0, 0, 1, 0, 4'h0);
        step(0, 1, 0, 0, 4'h4);
        step(0, 1, 0, 1, 4'h5);
        step(0, 1, 0, 2, 4'h6);
        checks++;
        if (a_fill !== 4'b0111) begin
            errors++; $display("FAIL midframe_pre got fill=%b want 0111", a_fill);
        end
        step(1, 1, 0, 3, 4'hD);
        checks++;
        if (obs_a !== 22'h0) begin
            errors++; $display("FAIL midframe_reset got %h want %h", obs_a, 22'h0);
        end
    endtask

    task automatic test_rolling();
        step(1, 0, 0, 0, 4'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, i, 4'($urandom_range(0, 15)));
        checks++;
        if (obs_b !== exp_pack(1) || b_frame !== 1'b1 || b_fill !== 4'hF) begin
            errors++; $display("FAIL rolling_first got %h want %h", obs_b, exp_pack(1));
        end
        step(0, 1, 0, 1, 4'h5);
        checks++;
        if (b_y1 !== 4'h5 || b_frame !== 1'b1 || b_fill !== 4'hF || b_err !== 1'b0) begin
            errors++; $display("FAIL rolling_update got y1=%h frame=%b fill=%b err=%b want 5 1 1111 0",
                               b_y1, b_frame, b_fill, b_err);
        end
        step(0, 1, 0, 1, 4'h7);
        checks++;
        if (obs_b !== exp_pack(1) || b_err !== 1'b0) begin
            errors++; $display("FAIL rolling_rewrite got %h want %h", obs_b, exp_pack(1));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)));
            checks++;
            if (obs_a !== exp_pack(0)) begin
                errors++; $display("FAIL random_framed cyc %0d got %h want %h", n, obs_a, exp_pack(0));
            end
            checks++;
            if (obs_b !== exp_pack(1)) begin
                errors++; $display("FAIL random_rolling cyc %0d got %h want %h", n, obs_b, exp_pack(1));
            end
        end
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; FLUSH = 1'b0; S0 = 1'b0; S1 = 1'b0; Din = 4'h0;
        test_reset();
        test_in_order();
        test_out_of_order();
        test_overwrite();
        test_flush();
        test_reset_midframe();
        test_rolling();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux4bit_4_frame.md
# demux4bit_4_frame

Registered 1-to-4 demultiplexer for 4-bit data, the receive-side counterpart of the 4-bit 4:1 multiplexer (MUX4bit_4). A time-multiplexed nibble stream (Din plus lane select S1:S0, qualified by EN) is steered into four staging registers. The block tracks which lanes have been filled. When all four lanes of a frame are present, it transfers them atomically into a stable output bank and pulses FRAME. It sits downstream of any MUX4bit_4-driven bus to reassemble the four parallel nibbles.

## Interface
- WIDTH, 4, data width of each lane (Din, staging, Y0..Y3).
- AUTOCLR, 1, 1: the fill flags clear after each completed frame (framed mode). 0: the flags stay full after the first frame (rolling mode).

- CLK  input  1  rising-edge clock; the only clock.
- RST  input  1  synchronous, active-high reset.
- Din  input  WIDTH  multiplexed data nibble.
- S0  input  1  lane select LSB.
- S1  input  1  lane select MSB; lane = {S1,S0}.
- EN  input  1  write strobe; Din and S1:S0 are sampled only when EN=1.
- FLUSH  input  1  discards a partial frame by clearing the fill flags.
- Y0, Y1, Y2, Y3  output  WIDTH each  frame output bank for lanes 0..3, registered.
- FILL  output  4  per-lane fill flags; bit n is set when lane n has been written in the current frame.
- FRAME  output  1  one-cycle pulse; Y0..Y3 were updated on this edge.
- ERR  output  1  one-cycle pulse; a lane was overwritten before the frame completed.

## Operation
- Internal staging registers: R0..R3 (WIDTH each).
- Reset (RST=1 at a rising CLK edge):
  - R0..R3, Y0..Y3, FILL, FRAME and ERR all go to 0.
  - RST overrides EN and FLUSH in the same cycle.
- Priority each edge, highest first: RST, then FLUSH, then EN write.
- FLUSH=1, EN=0: FILL <= 0000. R and Y keep their values. No FRAME or ERR.
- FLUSH=1, EN=1: FILL is cleared first, then the write is applied, so FILL <= one-hot(lane). R[lane] <= Din. No ERR.
- EN=1 write, lane = {S1,S0}:
  - R[lane] <= Din.
  - FILL_next = FILL | one-hot(lane).
- Overwrite (AUTOCLR=1, FILL[lane]=1 before the write):
  - R[lane] is overwritten.
  - FILL is unchanged.
  - ERR=1 for one cycle.
- Frame completion: FILL_next == 1111 on an EN write.
  - Y0..Y3 <= R0..R3, with the lane being written taking Din directly (bypass, no extra cycle).
  - FRAME=1 for one cycle.
  - AUTOCLR=1: FILL <= 0000 on the same edge.
  - AUTOCLR=0: FILL stays 1111. Every later EN write then completes a frame: it updates the written lane's Y and pulses FRAME. ERR is never raised in this mode.
- EN=0 and FLUSH=0: all registers hold. FRAME and ERR return to 0.
- Writes to lanes may occur in any order. Repeated writes to one lane before completion keep the last value.

## Timing
- All outputs are registered and change only on the rising CLK edge.
- Write-to-FILL latency: 1 edge.
- Final-lane-write-to-Y and FRAME: the same edge (1 cycle from the sample). FRAME is high during exactly the cycle in which the new Y values are first visible.
- ERR is asserted in the cycle after the offending edge, for one cycle only.
- Back-to-back EN writes every cycle are supported with no stall. A full frame takes a minimum of 4 consecutive cycles.
- FRAME and ERR can never both be 1, because an overwrite cannot complete a frame in framed mode.
- Reset mid-frame: the partial frame is lost, FILL returns to 0000, and Y0..Y3 go to 0.
- Y0..Y3 hold their last completed frame indefinitely between frames.

## Test plan
- Reset, then four writes: lanes 0,1,2,3 with Din = A,9,8,8 on consecutive cycles.
  - FILL steps 0001 -> 0011 -> 0111.
  - After the 4th edge: Y0..Y3 = A,9,8,8, FRAME=1 for one cycle, FILL=0000.
- Out-of-order frame: lanes 3,1,0,2 with Din = 1,6,F,2.
  - Y3,Y1,Y0,Y2 = 1,6,F,2 on the final edge.
  - Earlier Y values are unchanged until that edge.
- Overwrite: write lane 2 = E, then lane 2 = 3.
  - ERR=1 for one cycle after the second write, FILL=0100.
  - Complete the frame with lanes 0,1,3 = 0,0,0 -> Y2=3.
- Flush: write lanes 0,1 (FILL=0011), then FLUSH with EN=0 -> FILL=0000 and Y unchanged.
  - Next cycle, FLUSH and EN=1 on lane 3 with Din=B -> FILL=1000, no ERR.
- Reset mid-frame: FILL=0111, then assert RST together with EN on lane 3.
  - FILL=0000, Y0..Y3=0, FRAME=0; the lane-3 write is ignored.
- AUTOCLR=0: complete one frame, then write lane 1 = 5.
  - FRAME pulses, Y1=5, FILL stays 1111.
  - ERR stays 0 throughout.
